handshake_monitor: RTL and testbench
====================================

# handshake_monitor

Synthesizable, parametrised request/response protocol monitor for the pattern/checker environment. It is the hardware successor to the lab assertion checker: it watches CH independent in_valid/out_valid channel pairs, tracks one outstanding request per channel, and flags protocol violations. It also accumulates coverage-style statistics: transaction counts, worst-case latency and an optional latency histogram. It sits beside the DUT, observing only, and never drives DUT signals.

## Interface
- CH, 4: number of monitored channels (1..16)
- LAT_W, 10: latency counter width
- MAX_LAT, 1000: timeout threshold in cycles; must be < 2**LAT_W
- CNT_W, 16: width of every statistic counter
- HB, 4: histogram bin count (power of two)
- BIN_SZ, 8: latency span of one histogram bin
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of counters, sticky flags and max_lat; channel FSMs unaffected
- in_valid  in  CH  per-channel request pulse
- out_valid  in  CH  per-channel response pulse
- err_valid  out  1  one-cycle error report strobe
- err_code  out  2  01 = request while busy, 10 = orphan response, 11 = timeout
- err_ch  out  $clog2(CH) (min 1)  channel of the reported error
- err_multi  out  1  high with err_valid when more than one channel erred in that cycle
- err_sticky  out  CH  per-channel sticky error flag
- txn_cnt  out  CH*CNT_W  completed transactions per channel, channel 0 in the LSBs
- max_lat  out  LAT_W  largest completed latency over all channels
- hist  out  HB*CNT_W  latency histogram, bin 0 in the LSBs

## Operation
- Per-channel FSM with states IDLE and BUSY.
- IDLE + in_valid: go to BUSY and load the latency counter with 1.
- IDLE + out_valid: orphan error (10). If in_valid arrives in the same cycle, the request is still accepted and the channel goes to BUSY.
- BUSY + out_valid: completes the transaction; latency = current counter value. txn_cnt increments, max_lat updates, and the histogram bin updates.
  - BUSY + out_valid + in_valid: back-to-back transaction; the counter is reloaded with 1, the channel stays BUSY, and no error is raised.
  - BUSY + out_valid without in_valid: go to IDLE.
- BUSY + in_valid without out_valid: request-while-busy error (01). The original request is kept and the counter is not reloaded.
- BUSY, no out_valid, counter == MAX_LAT: timeout error (11) and go to IDLE. A later out_valid on that channel is an orphan error.
- The latency counter increments by 1 each BUSY cycle. It never wraps, because a timeout fires first.
- All statistic counters saturate at all-ones.
- Error reporting picks the lowest erring channel index; err_multi is set if any other channel also erred.
- Each channel produces at most one error code per cycle, with priority timeout > orphan > busy.
- clr takes precedence over a same-cycle increment: counters read 0 in the next cycle.
- Reset values are 0 for all outputs and all FSMs (IDLE).

## Timing
- The error is detected in cycle t. err_valid, err_code, err_ch and err_multi are high/valid in cycle t+1 only. err_sticky is set from t+1.
- A transaction completes in cycle t. txn_cnt, max_lat and hist reflect it in cycle t+1.
- Latency definition: in_valid in cycle t and out_valid in cycle t+k gives latency k (k ≥ 1).
- Reset assertion mid-transaction clears everything immediately and asynchronously. The first rising edge after rst_n deasserts is a normal IDLE cycle.

## Configuration
- HSMON_HIST_EN defined: the histogram is built. A completion with latency L increments bin min(L / BIN_SZ, HB-1).
- HSMON_HIST_EN undefined: no histogram registers are built and hist is tied to 0. All other behaviour is identical.

## Structure
- Package hsmon_pkg holds:
  - ch_state_t enum {IDLE, BUSY}
  - err_code_t enum {ERR_NONE=0, ERR_BUSY=1, ERR_ORPHAN=2, ERR_TIMEOUT=3}
  - a saturating-increment function
- Sub-module hsmon_chan, instantiated CH times, contains the FSM, latency counter, txn counter and a per-channel error code. It exports a completion strobe and the completed latency.
- The top level contains the priority encoder, the err_multi logic, max_lat comparison, histogram bins and output registers.

## Test plan
- in_valid[1] at cycle 10, out_valid[1] at cycle 15:
  - txn_cnt[1]=1 and max_lat=5 at cycle 16, with no err_valid.
  - With HSMON_HIST_EN, bin 0 = 1.
- out_valid[2] on an idle channel at cycle 20: at cycle 21, err_valid=1, err_code=10, err_ch=2, err_sticky[2]=1, err_multi=0.
- in_valid[0] and no response with MAX_LAT=1000: timeout at cycle 1000 after the request; err_code=11 one cycle later. A subsequent out_valid[0] gives err_code=10.
- Channel 3 back-to-back:
  - in_valid at cycle 0; in_valid plus out_valid at cycle 4; out_valid at cycle 6.
  - Result: txn_cnt[3]=2, max_lat=4, no error.
- Same-cycle errors: orphan on channel 1 and busy on channel 3 give err_ch=1, err_code=10, err_multi=1. Then clr: all counters, sticky flags and max_lat read 0 in the next cycle.
- rst_n pulled low while channel 0 is BUSY, then released: a following out_valid[0] reports an orphan error, and txn_cnt[0]=0.

Source files
------------

// File: rtl/hsmon_pkg.sv
// Shared types and helpers for the handshake monitor.
// Channel FSM states, error codes, a saturating adder for the statistic
// counters and the histogram bin selector.
package hsmon_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BUSY    = 2'b01,
        ERR_ORPHAN  = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    // Adds inc to val and clamps the result at the all-ones value of a
    // w-bit counter (w between 1 and 32).
    function automatic logic [31:0] sat_add(input logic [31:0] val,
                                            input logic [31:0] inc,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, val} + {1'b0, inc};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            return lim[31:0];
        end else begin
            return sum[31:0];
        end
    endfunction

    // Histogram bin for a completed latency: lat / bin_sz, clamped to the last bin.
    function automatic int unsigned hist_bin(input int unsigned lat,
                                             input int unsigned bin_sz,
                                             input int unsigned hb);
        int unsigned b;
        b = lat / bin_sz;
        if (b > hb - 32'd1) begin
            return hb - 32'd1;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/hsmon_chan.sv
// One monitored channel: IDLE/BUSY tracker for a single outstanding request,
// latency counter, completed-transaction counter and the error code raised
// by this channel in the current cycle. Completion strobe and the completed
// latency are combinational and get registered by the top level.
module hsmon_chan
    import hsmon_pkg::*;
#(
    parameter int LAT_W   = 10,
    parameter int MAX_LAT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic             out_valid_i,
    output err_code_t        err_code_o,
    output logic             done_o,
    output logic [LAT_W-1:0] done_lat_o,
    output logic [CNT_W-1:0] txn_cnt_o
);

    ch_state_t        state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    err_code_t        err_s;
    logic             done_s;

    // Next-state, latency counter and error classification for this channel.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        err_s   = ERR_NONE;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // A stray response is an orphan, but a same-cycle request is still taken.
                if (out_valid_i) begin
                    err_s = ERR_ORPHAN;
                end else begin
                    err_s = ERR_NONE;
                end
                if (in_valid_i) begin
                    state_d = BUSY;
                    lat_d   = LAT_W'(1'b1);
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (out_valid_i) begin
                    done_s = 1'b1;
                    if (in_valid_i) begin
                        // Back-to-back: next request starts right away.
                        lat_d = LAT_W'(1'b1);
                    end else begin
                        state_d = IDLE;
                        lat_d   = '0;
                    end
                end else if (lat_q == LAT_W'(MAX_LAT)) begin
                    // Timeout outranks a same-cycle duplicate request.
                    err_s   = ERR_TIMEOUT;
                    state_d = IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + LAT_W'(1'b1);
                    if (in_valid_i) begin
                        err_s = ERR_BUSY;
                    end else begin
                        err_s = ERR_NONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // Transaction counter: clear wins over a same-cycle completion.
    always_comb begin
        if (clr_i) begin
            txn_d = '0;
        end else if (done_s) begin
            txn_d = CNT_W'(sat_add(32'(txn_q), 32'd1, CNT_W));
        end else begin
            txn_d = txn_q;
        end
    end

    // Channel state registers; clr leaves the FSM and latency counter alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            txn_q   <= txn_d;
        end
    end

    assign err_code_o = err_s;
    assign done_o     = done_s;
    assign done_lat_o = lat_q;
    assign txn_cnt_o  = txn_q;

endmodule

// File: rtl/handshake_monitor.sv
// Passive request/response protocol monitor over CH channels.
// Reports the lowest-index erring channel one cycle after detection, keeps
// per-channel sticky error flags, transaction counts and the worst latency.
// Optional latency histogram is built when HSMON_HIST_EN is defined;
// otherwise hist is tied to zero.
module handshake_monitor
    import hsmon_pkg::*;
#(
    parameter int CH      = 4,
    parameter int LAT_W   = 10,
    parameter int MAX_LAT = 1000,
    parameter int CNT_W   = 16,
    parameter int HB      = 4,
    parameter int BIN_SZ  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clr,
    input  logic [CH-1:0]                           in_valid,
    input  logic [CH-1:0]                           out_valid,
    output logic                                    err_valid,
    output logic [1:0]                              err_code,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  err_ch,
    output logic                                    err_multi,
    output logic [CH-1:0]                           err_sticky,
    output logic [CH*CNT_W-1:0]                     txn_cnt,
    output logic [LAT_W-1:0]                        max_lat,
    output logic [HB*CNT_W-1:0]                     hist
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    // Elaboration-time parameter legality checks.
    if (CH < 1 || CH > 16) begin : g_bad_ch
        $error("handshake_monitor: CH must be 1..16");
    end
    if (MAX_LAT < 1 || MAX_LAT >= (2 ** LAT_W)) begin : g_bad_lat
        $error("handshake_monitor: MAX_LAT must be 1..2**LAT_W-1");
    end
    if (HB < 1 || (HB & (HB - 1)) != 0 || BIN_SZ < 1) begin : g_bad_hist
        $error("handshake_monitor: HB must be a power of two and BIN_SZ >= 1");
    end

    err_code_t        chan_err_s [CH];
    logic [CH-1:0]    done_s;
    logic [LAT_W-1:0] done_lat_s [CH];
    logic [CNT_W-1:0] chan_txn_s [CH];

    for (genvar g = 0; g < CH; g++) begin : g_chan
        hsmon_chan #(
            .LAT_W   (LAT_W),
            .MAX_LAT (MAX_LAT),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (clr),
            .in_valid_i  (in_valid[g]),
            .out_valid_i (out_valid[g]),
            .err_code_o  (chan_err_s[g]),
            .done_o      (done_s[g]),
            .done_lat_o  (done_lat_s[g]),
            .txn_cnt_o   (chan_txn_s[g])
        );
    end

    logic [CH-1:0]    err_vec_s;
    logic [4:0]       nerr_s;
    logic [CHW-1:0]   sel_ch_s;
    err_code_t        sel_code_s;
    logic             multi_s;

    logic             err_valid_q;
    logic [1:0]       err_code_q;
    logic [CHW-1:0]   err_ch_q;
    logic             err_multi_q;
    logic [CH-1:0]    sticky_q, sticky_d;
    logic [LAT_W-1:0] max_lat_q, max_lat_d, run_max_s;

    // Priority encoder: lowest erring channel wins, any further error sets multi.
    always_comb begin
        err_vec_s  = '0;
        nerr_s     = 5'd0;
        sel_ch_s   = '0;
        sel_code_s = ERR_NONE;
        multi_s    = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (chan_err_s[i] != ERR_NONE) begin
                err_vec_s[i] = 1'b1;
                nerr_s       = nerr_s + 5'd1;
                if (nerr_s == 5'd1) begin
                    sel_ch_s   = CHW'(i);
                    sel_code_s = chan_err_s[i];
                end else begin
                    multi_s = 1'b1;
                end
            end else begin
                err_vec_s[i] = 1'b0;
            end
        end
    end

    // Sticky flags and worst-case latency; clr beats same-cycle updates.
    always_comb begin
        run_max_s = max_lat_q;
        for (int i = 0; i < CH; i++) begin
            run_max_s = (done_s[i] && (done_lat_s[i] > run_max_s)) ? done_lat_s[i] : run_max_s;
        end
        if (clr) begin
            sticky_d  = '0;
            max_lat_d = '0;
        end else begin
            sticky_d  = sticky_q | err_vec_s;
            max_lat_d = run_max_s;
        end
    end

    // Error report strobe, sticky flags and max latency registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_ch_q    <= '0;
            err_multi_q <= 1'b0;
            sticky_q    <= '0;
            max_lat_q   <= '0;
        end else begin
            err_valid_q <= |err_vec_s;
            err_code_q  <= sel_code_s;
            err_ch_q    <= sel_ch_s;
            err_multi_q <= multi_s;
            sticky_q    <= sticky_d;
            max_lat_q   <= max_lat_d;
        end
    end

    // Pack per-channel transaction counters, channel 0 in the LSBs.
    always_comb begin
        txn_cnt = '0;
        for (int i = 0; i < CH; i++) begin
            txn_cnt[i*CNT_W +: CNT_W] = chan_txn_s[i];
        end
    end

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_ch     = err_ch_q;
    assign err_multi  = err_multi_q;
    assign err_sticky = sticky_q;
    assign max_lat    = max_lat_q;

`ifdef HSMON_HIST_EN
    logic [CNT_W-1:0] hist_q [HB];
    logic [CNT_W-1:0] hist_d [HB];
    logic [4:0]       bin_inc_s [HB];

    // Count same-cycle completions landing in each bin and add them saturating.
    always_comb begin
        for (int b = 0; b < HB; b++) begin
            bin_inc_s[b] = 5'd0;
            for (int i = 0; i < CH; i++) begin
                if (done_s[i] && (hist_bin(32'(done_lat_s[i]), BIN_SZ, HB) == 32'(b))) begin
                    bin_inc_s[b] = bin_inc_s[b] + 5'd1;
                end else begin
                    bin_inc_s[b] = bin_inc_s[b];
                end
            end
            if (clr) begin
                hist_d[b] = '0;
            end else begin
                hist_d[b] = CNT_W'(sat_add(32'(hist_q[b]), 32'(bin_inc_s[b]), CNT_W));
            end
        end
    end

    // Histogram bin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < HB; b++) begin
                hist_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < HB; b++) begin
                hist_q[b] <= hist_d[b];
            end
        end
    end

    // Pack histogram bins, bin 0 in the LSBs.
    always_comb begin
        hist = '0;
        for (int b = 0; b < HB; b++) begin
            hist[b*CNT_W +: CNT_W] = hist_q[b];
        end
    end
`else
    assign hist = '0;
`endif

endmodule

// File: tb/tb_handshake_monitor.sv
// Self-checking bench for handshake_monitor: directed scenarios plus a
// randomized run against a cycle-count based reference model.
module tb_handshake_monitor;

    localparam int CH      = 4;
    localparam int LAT_W   = 10;
    localparam int MAX_LAT = 1000;
    localparam int CNT_W   = 16;
    localparam int HB      = 4;
    localparam int BIN_SZ  = 8;
    localparam int CHW     = 2;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic                clk;
    logic                rst_n;
    logic                clr;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       out_valid;
    logic                err_valid;
    logic [1:0]          err_code;
    logic [CHW-1:0]      err_ch;
    logic                err_multi;
    logic [CH-1:0]       err_sticky;
    logic [CH*CNT_W-1:0] txn_cnt;
    logic [LAT_W-1:0]    max_lat;
    logic [HB*CNT_W-1:0] hist;

    int checks = 0;
    int errors = 0;

    handshake_monitor #(
        .CH(CH), .LAT_W(LAT_W), .MAX_LAT(MAX_LAT),
        .CNT_W(CNT_W), .HB(HB), .BIN_SZ(BIN_SZ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .out_valid(out_valid),
        .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
        .err_multi(err_multi), .err_sticky(err_sticky),
        .txn_cnt(txn_cnt), .max_lat(max_lat), .hist(hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: requests remembered by the edge index they arrived on.
    bit            m_busy  [CH];
    longint        m_start [CH];
    longint        m_txn   [CH];
    longint        m_hist  [HB];
    longint        m_max;
    longint        m_cyc = 0;
    logic [CH-1:0] m_sticky;
    logic          e_valid;
    logic [1:0]    e_code;
    int            e_ch;
    logic          e_multi;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_busy[c] = 1'b0; m_start[c] = 0; m_txn[c] = 0;
        end
        for (int b = 0; b < HB; b++) m_hist[b] = 0;
        m_max = 0; m_sticky = '0;
        e_valid = 1'b0; e_code = 2'b00; e_ch = 0; e_multi = 1'b0;
    endtask

    task automatic model_step(input logic [CH-1:0] iv, input logic [CH-1:0] ov, input logic cl);
        int     code [CH];
        int     n;
        longint lat;
        n = 0;
        e_valid = 1'b0; e_code = 2'b00; e_ch = 0; e_multi = 1'b0;
        for (int c = 0; c < CH; c++) begin
            code[c] = 0;
            if (m_busy[c]) begin
                lat = m_cyc - m_start[c];
                if (ov[c]) begin
                    m_txn[c] = (m_txn[c] < CNT_MAX) ? m_txn[c] + 1 : CNT_MAX;
                    if (lat > m_max) m_max = lat;
`ifdef HSMON_HIST_EN
                    begin
                        int b;
                        b = int'(lat) / BIN_SZ;
                        if (b > HB - 1) b = HB - 1;
                        m_hist[b] = (m_hist[b] < CNT_MAX) ? m_hist[b] + 1 : CNT_MAX;
                    end
`endif
                    if (iv[c]) m_start[c] = m_cyc;
                    else m_busy[c] = 1'b0;
                end else if (lat == MAX_LAT) begin
                    code[c] = 3; m_busy[c] = 1'b0;
                end else if (iv[c]) begin
                    code[c] = 1;
                end
            end else begin
                if (ov[c]) code[c] = 2;
                if (iv[c]) begin m_busy[c] = 1'b1; m_start[c] = m_cyc; end
            end
            if (code[c] != 0) begin
                n++;
                if (n == 1) begin e_valid = 1'b1; e_code = 2'(code[c]); e_ch = c; end
                else e_multi = 1'b1;
                m_sticky[c] = 1'b1;
            end
        end
        if (cl) begin
            for (int c = 0; c < CH; c++) m_txn[c] = 0;
            for (int b = 0; b < HB; b++) m_hist[b] = 0;
            m_max = 0; m_sticky = '0;
        end
        m_cyc++;
    endtask

    function automatic logic [CH*CNT_W-1:0] exp_txn();
        logic [CH*CNT_W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(m_txn[c]);
        return v;
    endfunction

    function automatic logic [HB*CNT_W-1:0] exp_hist();
        logic [HB*CNT_W-1:0] v;
        for (int b = 0; b < HB; b++) v[b*CNT_W +: CNT_W] = CNT_W'(m_hist[b]);
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, step the model, settle.
    task automatic tick(input logic [CH-1:0] iv, input logic [CH-1:0] ov, input logic cl);
        in_valid = iv; out_valid = ov; clr = cl;
        @(posedge clk);
        model_step(iv, ov, cl);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %b exp 0", err_valid); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code got %b exp 00", err_code); end
        checks++; if (err_ch !== 2'b00) begin errors++; $display("FAIL reset_err_ch got %0d exp 0", err_ch); end
        checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL reset_err_multi got %b exp 0", err_multi); end
        checks++; if (err_sticky !== 4'b0000) begin errors++; $display("FAIL reset_sticky got %b exp 0", err_sticky); end
        checks++; if (txn_cnt !== 64'd0) begin errors++; $display("FAIL reset_txn got %h exp 0", txn_cnt); end
        checks++; if (max_lat !== 10'd0) begin errors++; $display("FAIL reset_max_lat got %0d exp 0", max_lat); end
        checks++; if (hist !== 64'd0) begin errors++; $display("FAIL reset_hist got %h exp 0", hist); end
    endtask

    task automatic test_single();
        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b0010, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(4'b0000, 4'b0000, 1'b0);
            checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL single_wait_err got %b exp 0", err_valid); end
        end
        tick(4'b0000, 4'b0010, 1'b0);
        checks++; if (txn_cnt[CNT_W +: CNT_W] !== 16'd1) begin errors++; $display("FAIL single_txn1 got %0d exp 1", txn_cnt[CNT_W +: CNT_W]); end
        checks++; if (max_lat !== 10'd5) begin errors++; $display("FAIL single_max_lat got %0d exp 5", max_lat); end
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err_valid); end
`ifdef HSMON_HIST_EN
        checks++; if (hist[0 +: CNT_W] !== 16'd1) begin errors++; $display("FAIL single_bin0 got %0d exp 1", hist[0 +: CNT_W]); end
`else
        checks++; if (hist !== 64'd0) begin errors++; $display("FAIL single_hist_off got %h exp 0", hist); end
`endif
    endtask

    task automatic test_orphan();
        tick(4'b0000, 4'b0100, 1'b0);
        checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL orphan_valid got %b exp 1", err_valid); end
        checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL orphan_code got %b exp 10", err_code); end
        checks++; if (err_ch !== 2'd2) begin errors++; $display("FAIL orphan_ch got %0d exp 2", err_ch); end
        checks++; if (err_sticky[2] !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_sticky[2]); end
        checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL orphan_multi got %b exp 0", err_multi); end
        tick(4'b0000, 4'b0000, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL orphan_oneshot got %b exp 0", err_valid); end
    endtask

    task automatic test_timeout();
        tick(4'b0001, 4'b0000, 1'b0);
        for (int k = 1; k <= MAX_LAT; k++) begin
            tick(4'b0000, 4'b0000, 1'b0);
            if (k < MAX_LAT) begin
                if (err_valid !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL timeout_early at %0d got %b exp 0", k, err_valid);
                end
            end else begin
                checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid got %b exp 1", err_valid); end
                checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL timeout_code got %b exp 11", err_code); end
                checks++; if (err_ch !== 2'd0) begin errors++; $display("FAIL timeout_ch got %0d exp 0", err_ch); end
            end
        end
        tick(4'b0000, 4'b0001, 1'b0);
        checks++; if (err_code !== 2'b10 || err_valid !== 1'b1) begin errors++; $display("FAIL timeout_orphan got %b/%b exp 1/10", err_valid, err_code); end
    endtask

    task automatic test_back_to_back();
        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b1000, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b1000, 4'b1000, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err_valid); end
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b1000, 1'b0);
        checks++; if (txn_cnt[3*CNT_W +: CNT_W] !== 16'd2) begin errors++; $display("FAIL b2b_txn3 got %0d exp 2", txn_cnt[3*CNT_W +: CNT_W]); end
        checks++; if (max_lat !== 10'd4) begin errors++; $display("FAIL b2b_max_lat got %0d exp 4", max_lat); end
        checks++; if (err_valid !== 1'b0 || err_sticky !== 4'b0000) begin errors++; $display("FAIL b2b_noerr got %b/%b exp 0/0000", err_valid, err_sticky); end
`ifdef HSMON_HIST_EN
        checks++; if (hist[0 +: CNT_W] !== 16'd2) begin errors++; $display("FAIL b2b_bin0 got %0d exp 2", hist[0 +: CNT_W]); end
`endif
    endtask

    task automatic test_multi_clr();
        tick(4'b1000, 4'b0000, 1'b0);
        tick(4'b1000, 4'b0010, 1'b0);
        checks++; if (err_ch !== 2'd1) begin errors++; $display("FAIL multi_ch got %0d exp 1", err_ch); end
        checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL multi_code got %b exp 10", err_code); end
        checks++; if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_flag got %b exp 1", err_multi); end
        checks++; if (err_sticky !== 4'b1010) begin errors++; $display("FAIL multi_sticky got %b exp 1010", err_sticky); end
        tick(4'b0000, 4'b0000, 1'b1);
        checks++; if (txn_cnt !== 64'd0) begin errors++; $display("FAIL clr_txn got %h exp 0", txn_cnt); end
        checks++; if (err_sticky !== 4'b0000) begin errors++; $display("FAIL clr_sticky got %b exp 0", err_sticky); end
        checks++; if (max_lat !== 10'd0) begin errors++; $display("FAIL clr_max_lat got %0d exp 0", max_lat); end
        checks++; if (hist !== 64'd0) begin errors++; $display("FAIL clr_hist got %h exp 0", hist); end
        tick(4'b0000, 4'b1000, 1'b0);
        checks++; if (err_valid !== 1'b0 || txn_cnt[3*CNT_W +: CNT_W] !== 16'd1) begin errors++; $display("FAIL clr_fsm_kept got %b/%0d exp 0/1", err_valid, txn_cnt[3*CNT_W +: CNT_W]); end
    endtask

    task automatic test_async_reset();
        tick(4'b0001, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (txn_cnt !== 64'd0 || err_sticky !== 4'b0000 || max_lat !== 10'd0 || err_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got txn=%h sticky=%b max=%0d ev=%b exp all 0", txn_cnt, err_sticky, max_lat, err_valid);
        end
        #1 rst_n = 1'b1;
        tick(4'b0000, 4'b0001, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 2'b10 || err_ch !== 2'd0) begin errors++; $display("FAIL reset_orphan got %b/%b/%0d exp 1/10/0", err_valid, err_code, err_ch); end
        checks++; if (txn_cnt[0 +: CNT_W] !== 16'd0) begin errors++; $display("FAIL reset_txn0 got %0d exp 0", txn_cnt[0 +: CNT_W]); end
    endtask

    task automatic test_random();
        logic [CH-1:0] iv, ov;
        logic          cl;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                iv[c] = ($urandom_range(5) == 0);
                ov[c] = ($urandom_range(4) == 0);
            end
            cl = ($urandom_range(199) == 0);
            tick(iv, ov, cl);
            checks++; if (err_valid !== e_valid) begin errors++; $display("FAIL rnd_err_valid cyc %0d got %b exp %b", n, err_valid, e_valid); end
            checks++; if (err_code !== e_code) begin errors++; $display("FAIL rnd_err_code cyc %0d got %b exp %b", n, err_code, e_code); end
            checks++; if (err_ch !== CHW'(e_ch)) begin errors++; $display("FAIL rnd_err_ch cyc %0d got %0d exp %0d", n, err_ch, e_ch); end
            checks++; if (err_multi !== e_multi) begin errors++; $display("FAIL rnd_err_multi cyc %0d got %b exp %b", n, err_multi, e_multi); end
            checks++; if (err_sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky cyc %0d got %b exp %b", n, err_sticky, m_sticky); end
            checks++; if (txn_cnt !== exp_txn()) begin errors++; $display("FAIL rnd_txn cyc %0d got %h exp %h", n, txn_cnt, exp_txn()); end
            checks++; if (max_lat !== LAT_W'(m_max)) begin errors++; $display("FAIL rnd_max_lat cyc %0d got %0d exp %0d", n, max_lat, m_max); end
            checks++; if (hist !== exp_hist()) begin errors++; $display("FAIL rnd_hist cyc %0d got %h exp %h", n, hist, exp_hist()); end
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = '0; out_valid = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #2 rst_n = 1'b1;
        test_single();
        test_orphan();
        test_timeout();
        test_back_to_back();
        test_multi_clr();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
